// File: rtl/lfsr_pwm_mixer.sv
// Mixes up to three enabled LFSR noise channels into one 8-bit sample and
// plays it as a PWM waveform; inputs are latched only at PWM period boundaries.
module lfsr_pwm_mixer #(
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lfsr1,
  input  logic [7:0] lfsr2,
  input  logic [7:0] lfsr3,
  input  logic       en1,
  input  logic       en2,
  input  logic       en3,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic [1:0] active,
  output logic       playing,
  output logic       sample_strobe
);

  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 2;
  localparam int PROD_W = 17;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [PRE_W-1:0]    pre_cnt;
  logic [DATA_W-1:0]   pwm_cnt;
  logic                tick;
  logic                boundary;
  logic [DATA_W-1:0]   mix_p0;
  logic [1:0]          n_p0;

  function automatic logic [1:0] count_en(input logic ea, input logic eb, input logic ec);
    count_en = {1'b0, ea} + {1'b0, eb} + {1'b0, ec};
  endfunction

  // Averaging by channel count; the three-channel case approximates /3 as *85/256.
  function automatic logic [DATA_W-1:0] mix_sample(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic              ea,
    input logic              eb,
    input logic              ec
  );
    logic [SUM_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic [1:0]        n;
    sum  = (ea ? {2'b00, a} : SUM_W'(0))
         + (eb ? {2'b00, b} : SUM_W'(0))
         + (ec ? {2'b00, c} : SUM_W'(0));
    n    = count_en(ea, eb, ec);
    prod = PROD_W'(sum) * PROD_W'(85);
    case (n)
      2'd0:    mix_sample = '0;
      2'd1:    mix_sample = DATA_W'(sum);
      2'd2:    mix_sample = DATA_W'(sum >> 1);
      default: mix_sample = DATA_W'(prod >> 8);
    endcase
  endfunction

  // Timebase: prescaler tick drives the 8-bit PWM counter
  assign tick     = (pre_cnt == PRE_LAST);
  assign boundary = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Stage p0: mix of the inputs present in the current cycle
  assign mix_p0 = mix_sample(lfsr1, lfsr2, lfsr3, en1, en2, en3);
  assign n_p0   = count_en(en1, en2, en3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        IDLE:    if (n_p0 != 2'd0) state_d = PLAY;
        PLAY:    if (n_p0 == 2'd0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign playing = (state_q == PLAY);

  // Boundary latch and PWM compare; pwm_out uses pre-edge register values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty          <= '0;
      active        <= '0;
      sample_strobe <= 1'b0;
      pwm_out       <= 1'b0;
    end else begin
      sample_strobe <= boundary;
      if (boundary) begin
        duty   <= mix_p0;
        active <= n_p0;
      end
      pwm_out <= playing && (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_lfsr_pwm_mixer.sv
// Bench for lfsr_pwm_mixer: vector table applied period by period with a
// scoreboard of expected latched values, plus drop-out, async reset and PRESCALE=4 runs.
module tb_lfsr_pwm_mixer;

  typedef struct packed {
    logic       e1, e2, e3;
    logic [7:0] l1, l2, l3;
    logic [7:0] duty;
    logic [1:0] act;
    logic       play;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lfsr1, lfsr2, lfsr3;
  logic       en1, en2, en3;
  logic       pwm_out, playing, sample_strobe;
  logic [7:0] duty;
  logic [1:0] active;

  logic       reset4;
  logic [7:0] l4_1, l4_2, l4_3;
  logic       e4_1, e4_2, e4_3;
  logic       pwm4, playing4, strobe4;
  logic [7:0] duty4;
  logic [1:0] active4;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t vecs[11];
  vec_t v128, vzero, nxt;

  always #5 clk = ~clk;

  lfsr_pwm_mixer #(.PRESCALE(1), .PRE_W(8)) dut (
    .clk(clk), .reset(reset),
    .lfsr1(lfsr1), .lfsr2(lfsr2), .lfsr3(lfsr3),
    .en1(en1), .en2(en2), .en3(en3),
    .pwm_out(pwm_out), .duty(duty), .active(active),
    .playing(playing), .sample_strobe(sample_strobe)
  );

  lfsr_pwm_mixer #(.PRESCALE(4), .PRE_W(3)) dut4 (
    .clk(clk), .reset(reset4),
    .lfsr1(l4_1), .lfsr2(l4_2), .lfsr3(l4_3),
    .en1(e4_1), .en2(e4_2), .en3(e4_3),
    .pwm_out(pwm4), .duty(duty4), .active(active4),
    .playing(playing4), .sample_strobe(strobe4)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    en1 = v.e1; en2 = v.e2; en3 = v.e3;
    lfsr1 = v.l1; lfsr2 = v.l2; lfsr3 = v.l3;
    sb.push_back(v);
  endtask

  task automatic check_boundary();
    vec_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      chk("bnd_duty", int'(duty), int'(e.duty));
      chk("bnd_active", int'(active), int'(e.act));
      chk("bnd_playing", int'(playing), int'(e.play));
      cur = e;
    end
  endtask

  // One full PWM period starting just after a strobe sample; next inputs driven at sample 'at'
  task automatic run_period(input vec_t nv, input int at);
    int highs = 0;
    int extra = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      highs += int'(pwm_out);
      if (k < 256 && sample_strobe) extra++;
      if (k == at) drive(nv);
      if (k == 200) chk("duty_hold", int'(duty), int'(cur.duty));
    end
    chk("strobe_extra", extra, 0);
    chk("boundary_strobe", int'(sample_strobe), 1);
    chk("pwm_highs", highs, cur.play ? int'(cur.duty) : 0);
  endtask

  initial begin
    int h0, h4, x4;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h40, 8'd0,   8'd0,   8'd64,  2'd1, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd200, 8'd100, 8'd0,  8'd150, 2'd2, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd100, 8'd0,  8'd50,  2'd2, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd254, 2'd3, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd99,  8'd7,   8'd0,  8'd7,   2'd1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'd255, 8'd0,   8'd255, 8'd255, 2'd2, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd1,   8'd2,  8'd1,   2'd2, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd10,  8'd20,  8'd30, 8'd19,  2'd3, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd77,  8'd88,  8'd99, 8'd0,   2'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,  8'd0,   2'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'd1,   8'd1,   8'd1,  8'd0,   2'd3, 1'b1};
    v128     = '{1'b1, 1'b0, 1'b0, 8'd128, 8'd0,   8'd0,  8'd128, 2'd1, 1'b1};
    vzero    = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,  8'd0,   2'd0, 1'b0};

    reset = 1'b1; reset4 = 1'b1;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    lfsr1 = 8'd0; lfsr2 = 8'd0; lfsr3 = 8'd0;
    e4_1 = 1'b1; e4_2 = 1'b0; e4_3 = 1'b0;
    l4_1 = 8'h20; l4_2 = 8'h00; l4_3 = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_strobe", int'(sample_strobe), 0);

    cur = vzero;
    run_period(vecs[0], 100);
    for (int i = 0; i < 11; i++) begin
      check_boundary();
      if (i < 10) nxt = vecs[i+1];
      else        nxt = v128;
      run_period(nxt, 100);
    end

    // Enables drop at pwm_cnt=10: the period still completes at duty 128
    check_boundary();
    run_period(vzero, 10);
    check_boundary();
    run_period(v128, 100);
    check_boundary();

    // Async reset mid-period, checked before the next clock edge
    repeat (50) @(negedge clk);
    chk("pre_rst_pwm_out", int'(pwm_out), 1);
    reset = 1'b1;
    #1;
    chk("async_pwm_out", int'(pwm_out), 0);
    chk("async_duty", int'(duty), 0);
    chk("async_playing", int'(playing), 0);
    chk("async_active", int'(active), 0);
    chk("async_strobe", int'(sample_strobe), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // PRESCALE=4: 1024-clk period, duty 32 -> 128 high clks per period
    @(negedge clk);
    reset4 = 1'b0;
    h0 = 0; h4 = 0; x4 = 0;
    for (int k = 1; k <= 2048; k++) begin
      @(negedge clk);
      if (k == 1023) chk("p4_strobe_early", int'(strobe4), 0);
      if (k == 1024) begin
        chk("p4_strobe", int'(strobe4), 1);
        chk("p4_duty", int'(duty4), 32);
        chk("p4_active", int'(active4), 1);
        chk("p4_playing", int'(playing4), 1);
      end
      if (k == 1025) chk("p4_strobe_width", int'(strobe4), 0);
      if (k <= 1024) h0 += int'(pwm4);
      else           h4 += int'(pwm4);
      if (k > 1025 && k < 2048 && strobe4) x4++;
    end
    chk("p4_idle_highs", h0, 0);
    chk("p4_pwm_highs", h4, 128);
    chk("p4_strobe_extra", x4, 0);
    chk("p4_second_strobe", int'(strobe4), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
